serial_twos_receiver: RTL and testbench

//   Receive end of the bit-serial two's-complement link. Accepts an LSB-first

---
 rtl/serial_twos_receiver.sv | 121 ++++++++++++
 tb/tb_serial_twos_receiver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_receiver.sv
// Serial two's-complement receiver: takes an LSB-first bit stream framed by
// a start strobe, negates it on the fly (copy through the first 1, invert
// after) and presents the result as a parallel word with a valid pulse.
module serial_twos_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             Bin,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             ovf,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic             valid_reg, valid_next;
    logic             ovf_reg, ovf_next;
    logic             frame_err_reg, frame_err_next;

    // Working signals for the bit being accepted this cycle
    logic             accept;
    logic             first;
    logic             in_copy;
    logic             conv;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] shift_base;

    // State, counter, shift register and registered output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            shift_reg     <= '0;
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            shift_reg     <= shift_next;
            data_out_reg  <= data_out_next;
            valid_reg     <= valid_next;
            ovf_reg       <= ovf_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic: framing, on-the-fly negation and word completion
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        shift_next     = shift_reg;
        data_out_next  = data_out_reg;
        valid_next     = 1'b0;
        ovf_next       = 1'b0;
        frame_err_next = 1'b0;
        accept         = 1'b0;
        first          = 1'b0;
        idx            = count_reg;
        shift_base     = shift_reg;

        if (bit_en) begin
            if (start) begin
                // A start always begins a fresh word; mid-word it flags the
                // discarded partial word.
                accept         = 1'b1;
                first          = 1'b1;
                idx            = '0;
                shift_base     = '0;
                frame_err_next = (state_reg != IDLE);
            end else if (state_reg != IDLE) begin
                accept = 1'b1;
            end
        end

        // A starting bit is always treated under the COPY rule
        in_copy = first || (state_reg == COPY);
        conv    = in_copy ? Bin : ~Bin;

        if (accept) begin
            // Right shift with the new bit entering at the MSB, so the LSB
            // that arrived first lands in bit 0 once the word is complete.
            shift_next            = shift_base >> 1;
            shift_next[WIDTH-1]   = conv;

            if (idx == LAST) begin
                data_out_next = shift_next;
                valid_next    = 1'b1;
                // Only 100..0 reaches the MSB still in COPY with a 1
                ovf_next      = in_copy && Bin;
                state_next    = IDLE;
                count_next    = '0;
            end else begin
                state_next = (in_copy && !Bin) ? COPY : INVERT;
                count_next = idx + CW'(1);
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = valid_reg;
    assign ovf        = ovf_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_serial_twos_receiver.sv
// Directed bench for serial_twos_receiver at WIDTH=8.
module tb_serial_twos_receiver;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       Bin;
    logic       start;
    logic [7:0] data_out;
    logic       data_valid;
    logic       ovf;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    // Pulse bookkeeping gathered after every clock edge
    int   valid_cnt;
    int   ferr_cnt;
    int   stray_cnt;
    logic last_ovf;

    serial_twos_receiver #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .Bin        (Bin),
        .start      (start),
        .data_out   (data_out),
        .data_valid (data_valid),
        .ovf        (ovf),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        ferr_cnt  = 0;
        stray_cnt = 0;
        last_ovf  = 1'b0;
    endtask

    // Sample outputs 1 time unit after the active edge
    task automatic sample();
        @(posedge clk);
        #1;
        if (data_valid) begin
            valid_cnt++;
            last_ovf = ovf;
        end
        if (frame_err) ferr_cnt++;
        if ((ovf && !data_valid) || (frame_err && data_valid)) stray_cnt++;
    endtask

    task automatic send_bit(input logic b, input logic st);
        @(negedge clk);
        bit_en = 1'b1;
        Bin    = b;
        start  = st;
        sample();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_en = 1'b0;
        Bin    = 1'b0;
        start  = 1'b0;
        sample();
    endtask

    task automatic send_word(input logic [7:0] v, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], i == 0);
            if (gap > 0 && i < 7)
                for (int g = 0; g < gap; g++) idle_cycle();
        end
    endtask

    initial begin
        logic [7:0] pat;
        reset  = 1'b1;
        bit_en = 1'b0;
        Bin    = 1'b0;
        start  = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", data_out, 8'h00);
        check("reset flags", {data_valid, ovf, frame_err}, 3'b000);
        @(negedge clk);
        reset = 1'b0;

        // Bits without a start are ignored
        clear_counts();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        idle_cycle();
        check("no start ignored", valid_cnt, 0);

        // 1: 0x05 -> 0xFB
        clear_counts();
        send_word(8'h05, 0);
        check("t1 data", data_out, 8'hFB);
        check("t1 valid", valid_cnt, 1);
        check("t1 ovf", last_ovf, 1'b0);
        idle_cycle();
        check("t1 valid one cycle", data_valid, 1'b0);
        check("t1 data held", data_out, 8'hFB);

        // 2: 0x00 -> 0x00, then 0x80 -> 0x80 with ovf
        clear_counts();
        send_word(8'h00, 0);
        check("t2 zero data", data_out, 8'h00);
        check("t2 zero ovf", last_ovf, 1'b0);
        idle_cycle();
        send_word(8'h80, 0);
        check("t2 min data", data_out, 8'h80);
        check("t2 min ovf", last_ovf, 1'b1);
        check("t2 valid", valid_cnt, 2);

        // 3: 0xFF with 3-cycle gaps -> 0x01, valid only after bit 7
        clear_counts();
        pat = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            send_bit(pat[i], i == 0);
            for (int g = 0; g < 3; g++) idle_cycle();
        end
        check("t3 no early valid", valid_cnt, 0);
        send_bit(pat[7], 1'b0);
        check("t3 data", data_out, 8'h01);
        check("t3 valid", valid_cnt, 1);

        // 4: partial word then restart with 0x06 -> frame_err, 0xFA
        clear_counts();
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("t4 no partial valid", valid_cnt, 0);
        send_bit(1'b0, 1'b1);
        check("t4 frame_err pulse", frame_err, 1'b1);
        pat = 8'h06;
        for (int i = 1; i < 8; i++) send_bit(pat[i], 1'b0);
        check("t4 data", data_out, 8'hFA);
        check("t4 frame_err count", ferr_cnt, 1);
        check("t4 valid", valid_cnt, 1);

        // 5: 0x01 then 0x7F back-to-back -> 0xFF, 0x81
        clear_counts();
        send_word(8'h01, 0);
        check("t5 first data", data_out, 8'hFF);
        send_word(8'h7F, 0);
        check("t5 second data", data_out, 8'h81);
        check("t5 valid", valid_cnt, 2);
        check("t5 frame_err", ferr_cnt, 0);

        // 6: asynchronous reset mid-word, then 0x03 -> 0xFD
        clear_counts();
        pat = 8'h3C;
        for (int i = 0; i < 4; i++) send_bit(pat[i], i == 0);
        bit_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6 async data_out", data_out, 8'h00);
        check("t6 async flags", {data_valid, ovf, frame_err}, 3'b000);
        #4;
        reset = 1'b0;
        // Continuation bits of the lost word must be ignored
        for (int i = 4; i < 8; i++) send_bit(pat[i], 1'b0);
        check("t6 lost word", valid_cnt, 0);
        send_word(8'h03, 0);
        check("t6 data", data_out, 8'hFD);
        check("t6 valid", valid_cnt, 1);
        check("t6 frame_err", ferr_cnt, 0);

        idle_cycle();
        check("stray pulses", stray_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
